// File: rtl/sort4_ctrl.sv
// rtl/sort4_ctrl.sv - four-element load/bubble-sort/drain controller with one shared comparator.
// Define SORT4_SIGNED_EN to let a latched sign=1 select two's-complement ordering.

module sort4_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             gt_o
);
  always_comb begin
    gt_o = 1'b0;
    if (signed_i) gt_o = ($signed(a_i) > $signed(b_i));
    else          gt_o = (a_i > b_i);
  end
endmodule

module sort4_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sign,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [2:0]       swaps
);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] elem_q [4];
  logic [WIDTH-1:0] elem_d [4];
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       step_q, step_d;
  logic             sign_q, sign_d;
  logic [2:0]       swaps_q, swaps_d;

  logic [1:0]       j, j1;
  logic             cmp_signed;
  logic             gt;

  // Bubble-sort pass schedule: pairs (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
  always_comb begin
    case (step_q)
      3'd1, 3'd4: j = 2'd1;
      3'd2:       j = 2'd2;
      default:    j = 2'd0;
    endcase
  end
  assign j1 = j + 2'd1;

`ifdef SORT4_SIGNED_EN
  assign cmp_signed = sign_q;
`else
  logic unused_sign;
  assign unused_sign = sign_q;
  assign cmp_signed  = 1'b0;
`endif

  sort4_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a_i      (elem_q[j]),
    .b_i      (elem_q[j1]),
    .signed_i (cmp_signed),
    .gt_o     (gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) elem_q[i] <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      sign_q  <= 1'b0;
      swaps_q <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) elem_q[i] <= elem_d[i];
      idx_q   <= idx_d;
      step_q  <= step_d;
      sign_q  <= sign_d;
      swaps_q <= swaps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < 4; i++) elem_d[i] = elem_q[i];
    idx_d   = idx_q;
    step_d  = step_q;
    sign_d  = sign_q;
    swaps_d = swaps_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          elem_d[0] = in_data;
          sign_d    = sign;
          swaps_d   = '0;
          idx_d     = 2'd1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          elem_d[idx_q] = in_data;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            idx_d   = '0;
            step_d  = '0;
            state_d = SORT;
          end
        end
      end
      SORT: begin
        if (gt) begin
          elem_d[j]  = elem_q[j1];
          elem_d[j1] = elem_q[j];
          swaps_d    = (swaps_q == 3'd6) ? 3'd6 : swaps_q + 3'd1;
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd5) begin
          step_d  = '0;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = (state_q == DRAIN) ? elem_q[idx_q] : '0;
  assign busy      = (state_q != IDLE);
  assign swaps     = swaps_q;

endmodule

// File: tb/tb_sort4_ctrl.sv
// tb/tb_sort4_ctrl.sv - randomized self-checking bench for sort4_ctrl against a rank/inversion model.

module tb_sort4_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sign;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [2:0] swaps;

  int checks;
  int errors;

`ifdef SORT4_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic [3:0] stim [4];
  logic [3:0] exp_out [4];
  int         exp_swaps;

  sort4_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sign      (sign),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .swaps     (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ordering key: in signed mode flipping the MSB maps two's-complement onto unsigned order.
  function automatic int key(input logic [3:0] v, input logic s);
    logic [3:0] k;
    k = (s && SIGNED_EN) ? (v ^ 4'h8) : v;
    return int'(k);
  endfunction

  // Output = elements ranked by key (earliest wins ties); swaps = inversion count.
  task automatic build_model(input logic s);
    bit used [4];
    int best;
    for (int i = 0; i < 4; i++) used[i] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      best = -1;
      for (int i = 0; i < 4; i++)
        if (!used[i] && (best < 0 || key(stim[i], s) < key(stim[best], s))) best = i;
      used[best]  = 1'b1;
      exp_out[p]  = stim[best];
    end
    exp_swaps = 0;
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if (key(stim[a], s) > key(stim[b], s)) exp_swaps++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_swaps"},     swaps,     0);
  endtask

  // Called at a negedge with the DUT idle; returns just after the 4th beat edge.
  task automatic load4(input logic s, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
      check("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = stim[i];
      sign     = (i == 0) ? s : 1'($urandom);
      @(posedge clk);
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic run_case(input string name, input logic s, input int gap_max,
                          input int bp_max, input bit noise);
    int cnt;
    build_model(s);
    load4(s, gap_max);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      in_valid = noise;
      in_data  = 4'($urandom);
      if (cnt == 1) begin
        check({name, "_sort_in_ready"}, in_ready, 0);
        check({name, "_sort_busy"}, busy, 1);
      end
    end while (!out_valid && cnt < 20);
    check({name, "_latency"}, cnt, 7);
    check({name, "_swaps"}, swaps, exp_swaps);
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      repeat ((k == 0 && bp_max > 0) ? 3 : $urandom_range(0, bp_max)) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = noise;
        in_data  = 4'($urandom);
        check({name, "_hold_valid"}, out_valid, 1);
        check({name, "_hold_data"}, out_data, exp_out[k]);
      end
      check({name, "_valid"}, out_valid, 1);
      check({name, $sformatf("_out%0d", k)}, out_data, exp_out[k]);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
    check({name, "_done_valid"}, out_valid, 0);
    check({name, "_done_busy"}, busy, 0);
    check({name, "_done_in_ready"}, in_ready, 1);
    check({name, "_done_swaps"}, swaps, exp_swaps);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    sign      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("reset0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    stim[0] = 4'd9; stim[1] = 4'd3; stim[2] = 4'd7; stim[3] = 4'd1;
    run_case("unsigned", 1'b0, 0, 0, 1'b0);
    check("unsigned_swaps5", swaps, 5);

    stim[0] = 4'h7; stim[1] = 4'h8; stim[2] = 4'h0; stim[3] = 4'hF;
    run_case("signed", 1'b1, 1, 2, 1'b0);

    stim[0] = 4'd1; stim[1] = 4'd2; stim[2] = 4'd3; stim[3] = 4'd4;
    run_case("presorted", 1'b0, 0, 1, 1'b0);
    check("presorted_swaps0", swaps, 0);

    stim[0] = 4'd5; stim[1] = 4'd5; stim[2] = 4'd2; stim[3] = 4'd5;
    run_case("dups", 1'b0, 0, 0, 1'b0);
    check("dups_swaps2", swaps, 2);

    stim[0] = 4'd6; stim[1] = 4'd2; stim[2] = 4'd8; stim[3] = 4'd4;
    run_case("backpressure", 1'b0, 2, 3, 1'b1);

    // Reset during the 3rd SORT cycle, then a fully reversed load.
    stim[0] = 4'd9; stim[1] = 4'd3; stim[2] = 4'd7; stim[3] = 4'd1;
    load4(1'b0, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_sort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_reset_no_output", out_valid, 0);
    end
    stim[0] = 4'd4; stim[1] = 4'd3; stim[2] = 4'd2; stim[3] = 4'd1;
    run_case("reversed", 1'b0, 0, 0, 1'b0);
    check("reversed_swaps6", swaps, 6);

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 4; i++) stim[i] = 4'($urandom);
      run_case($sformatf("rand%0d", it), 1'($urandom), 2, 3, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, element width in bits; fixed at 4 to match the team's 4-bit comparator.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: sign  input  1  compare mode, 0 = unsigned, 1 = two's-complement; sampled on the first accepted load beat.
REQ-006 Port: in_valid  input  1  in_data is valid this cycle.
REQ-007 Port: in_data  input  WIDTH  element to load.
REQ-008 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port: out_valid  output  1  out_data is valid this cycle.
REQ-010 Port: out_data  output  WIDTH  sorted element, smallest first.
REQ-011 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 Port: busy  output  1  high in LOAD, SORT and DRAIN.
REQ-013 Port: swaps  output  3  number of swaps performed in the current or last sort (0..6).

Function
REQ-014 States SHALL be IDLE, LOAD, SORT and DRAIN, held in a registered state machine.
REQ-015 A beat SHALL transfer on a clock edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and LOAD and 0 in SORT and DRAIN.
REQ-016 IDLE: the first beat SHALL store element[0], latch sign, clear swaps and go to LOAD.
REQ-017 LOAD: beats SHALL fill element[1..3] in order; on the 4th beat the state SHALL go to SORT.
REQ-018 SORT SHALL last exactly 6 cycles, with one compare-and-swap per cycle on pair (j, j+1), j sequence 0,1,2,0,1,0 (bubble sort); swaps go through a single shared comparator instance.
REQ-019 Order SHALL be ascending: swap only if element[j] > element[j+1] under the latched mode; equal values SHALL NOT swap (stable sort).
REQ-020 swaps SHALL increment by 1 on each swap and saturate at 6; it SHALL hold its value through DRAIN and IDLE until the next first load beat.
REQ-021 After the 6th SORT cycle the state SHALL go to DRAIN, with out_valid=1 and out_data=element[0] in the first DRAIN cycle.
REQ-022 DRAIN: each edge with out_valid & out_ready SHALL advance to the next element; out_data SHALL stay stable while out_ready=0.
REQ-023 The 4th output handshake SHALL return the state to IDLE with out_valid=0 on the next cycle.
REQ-024 in_valid SHALL be ignored in SORT and DRAIN, and out_ready SHALL be ignored outside DRAIN.
REQ-025 Latency from the 4th load beat edge to the first out_valid=1 SHALL be 7 clock cycles.
REQ-026 The state SHALL NOT change while in_valid=0 (IDLE/LOAD) or out_ready=0 (DRAIN), and no timeout applies.

Reset
REQ-027 When rst_n=0, the block SHALL go immediately, without a clock, to IDLE with in_ready=1, out_valid=0, out_data=0, busy=0, swaps=0, all elements 0, counters 0 and latched sign 0.
REQ-028 Reset asserted mid-LOAD, SORT or DRAIN SHALL discard all data, and no partial output SHALL appear after release.

Configuration
REQ-029 Macro SORT4_SIGNED_EN, when defined, SHALL make a latched sign=1 select two's-complement comparison.
REQ-030 Without SORT4_SIGNED_EN, the sign port SHALL remain present but be ignored, and all comparisons SHALL be unsigned.

Verification
REQ-031 Unsigned test: load 9,3,7,1 with sign=0 -> outputs 1,3,7,9; swaps=5; first out_valid 7 cycles after the 4th beat.
REQ-032 Signed test with SORT4_SIGNED_EN: load 7,8,0,F (hex) with sign=1 -> outputs 8,F,0,7 (-8,-1,0,7); without the macro, the same input -> 0,7,8,F.
REQ-033 Pre-sorted and duplicate test: load 1,2,3,4 -> outputs 1,2,3,4 with swaps=0; load 5,5,2,5 -> outputs 2,5,5,5 with swaps=2.
REQ-034 Backpressure test: out_ready=0 for 3 cycles in DRAIN -> out_data held at element[0] and out_valid=1; in_valid=1 during SORT and DRAIN -> no beat accepted.
REQ-035 Reset test: rst_n pulsed low during the 3rd SORT cycle -> immediate IDLE with all outputs at reset values; a new load of 4,3,2,1 -> outputs 1,2,3,4 with swaps=6.
